mdu_sequencer: RTL and testbench

- Multi-cycle unsigned multiply/divide unit for the RV32 core.
- Owns no adder of its own: on every iteration it drives the shared 32-bit ALU (control, left/right operands) and captures the ALU result.
- Sits beside the execute stage. The core holds its ALU mux on this block while busy=1.

---
 rtl/mdu_sequencer.sv | 173 +++++++++++++++++
 tb/tb_mdu_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// -----------------------------------------------------------------------------
// mdu_sequencer
//   Multi-cycle unsigned multiply / divide sequencer for the RV32 core. It has
//   no adder of its own. Each RUN cycle it drives the shared ALU and captures
//   the ALU result. Multiply uses shift-and-add (MULU, low word). Divide uses
//   restoring division (DIVU quotient, REMU remainder). Every operation takes
//   exactly WIDTH iterations.
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   reset        synchronous, active-high reset
//   start        request pulse, accepted only in IDLE or DONE
//   op           00 MULU, 01 DIVU, 10 REMU, 11 MULU
//   operand_a    multiplicand / dividend, sampled on accept
//   operand_b    multiplier / divisor, sampled on accept
//   busy         high while iterating
//   done         one-cycle pulse, result valid
//   result       registered result, held until the next completion
//   alu_control  ALU opcode driven to the shared ALU (ADD=010, SUB=110)
//   alu_left     ALU left operand
//   alu_right    ALU right operand
//   alu_result   combinational ALU result for the current operands
// -----------------------------------------------------------------------------
module mdu_sequencer #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       alu_control,
    output logic [WIDTH-1:0] alu_left,
    output logic [WIDTH-1:0] alu_right,
    input  logic [WIDTH-1:0] alu_result
);

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REMU = 2'b10;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       op_q;

    // Multiply datapath
    logic [WIDTH-1:0] acc, mcand, mplier;
    // Divide datapath
    logic [WIDTH-1:0] rem, quot, divisor;

    logic             is_mul;
    logic             last;
    logic [WIDTH-1:0] rs;
    logic             carry;
    logic             ge;
    logic [WIDTH-1:0] acc_nxt, rem_nxt, quot_nxt;

    // Op code 11 falls through to multiply.
    assign is_mul = !((op_q == OP_DIVU) || (op_q == OP_REMU));
    assign last   = (cnt == CNT_W'(WIDTH - 1));

    // Restoring divide step. The bit shifted out of rem is an implicit
    // 33rd bit: when it is set, the shifted remainder exceeds any divisor,
    // so the subtraction is always taken. The compare stays local; only the
    // subtraction goes through the ALU.
    assign rs       = {rem[WIDTH-2:0], quot[WIDTH-1]};
    assign carry    = rem[WIDTH-1];
    assign ge       = carry | (rs >= divisor);
    assign rem_nxt  = ge ? alu_result : rs;
    assign quot_nxt = {quot[WIDTH-2:0], ge};

    assign acc_nxt  = mplier[0] ? alu_result : acc;

    // ALU drive depends on the current registers, so alu_result reflects
    // this cycle's iteration. The ALU is parked at ADD 0+0 outside RUN.
    always_comb begin
        alu_control = ALU_ADD;
        alu_left    = '0;
        alu_right   = '0;
        if (state == RUN) begin
            if (is_mul) begin
                alu_control = ALU_ADD;
                alu_left    = acc;
                alu_right   = mcand;
            end else begin
                alu_control = ALU_SUB;
                alu_left    = rs;
                alu_right   = divisor;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            op_q    <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            rem     <= '0;
            quot    <= '0;
            divisor <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    // In DONE, done is already high this cycle. A start here
                    // is accepted while the pulse still completes.
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        op_q  <= op;
                        if ((op == OP_DIVU) || (op == OP_REMU)) begin
                            rem     <= '0;
                            quot    <= operand_a;
                            divisor <= operand_b;
                        end else begin
                            acc    <= '0;
                            mcand  <= operand_a;
                            mplier <= operand_b;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end

                RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (is_mul) begin
                        acc    <= acc_nxt;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end else begin
                        rem  <= rem_nxt;
                        quot <= quot_nxt;
                    end
                    // The final iteration's values are captured directly
                    // into result on the same edge.
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        if (is_mul)
                            result <= acc_nxt;
                        else if (op_q == OP_DIVU)
                            result <= quot_nxt;
                        else
                            result <= rem_nxt;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mdu_sequencer
//   Self-checking bench for mdu_sequencer. A behavioural shared ALU is wired to
//   the DUT. Expected results come from a reference model. They are queued
//   when an operation is issued and compared by a monitor on each done pulse.
//   Scenario tasks check timing, ALU control, start filtering and reset abort.
// -----------------------------------------------------------------------------
module tb_mdu_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] operand_a = '0;
    logic [W-1:0] operand_b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [2:0]   alu_control;
    logic [W-1:0] alu_left;
    logic [W-1:0] alu_right;
    logic [W-1:0] alu_result;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [W-1:0] val;
        string        name;
    } exp_t;

    exp_t exp_q[$];

    mdu_sequencer #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .alu_control (alu_control),
        .alu_left    (alu_left),
        .alu_right   (alu_right),
        .alu_result  (alu_result)
    );

    always #5 clk = ~clk;

    // Shared ALU model: SUB for 110, ADD otherwise.
    assign alu_result = (alu_control == 3'b110) ? (alu_left - alu_right)
                                                : (alu_left + alu_right);

    function automatic logic [W-1:0] model(input logic [1:0] o,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W-1:0] r;
        case (o)
            2'b01:   r = (b == 0) ? '1 : a / b;
            2'b10:   r = (b == 0) ? a  : a % b;
            default: r = a * b;
        endcase
        return r;
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest pending op.
    always @(negedge clk) begin
        if (reset === 1'b0 && done === 1'b1) begin
            exp_t ex;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: result=%h with no pending op", result);
            end else begin
                ex = exp_q.pop_front();
                if (result !== ex.val) begin
                    fails++;
                    $display("FAIL %s: result=%h expected=%h", ex.name, result, ex.val);
                end
            end
        end
    end

    // Issue one op at the current negedge and follow it to done.
    // cyc = negedge index (1-based after the accept edge) on which done was seen,
    // -1 if not within the bound.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input string nm,
                          output int cyc, output int busy_n, output bit ctrl_ok);
        logic [2:0] want;
        exp_t       ex;
        want    = (o == 2'b01 || o == 2'b10) ? 3'b110 : 3'b010;
        ex.val  = model(o, a, b);
        ex.name = nm;
        exp_q.push_back(ex);
        op = o; operand_a = a; operand_b = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = -1; busy_n = 0; ctrl_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy === 1'b1) begin
                busy_n++;
                if (alu_control !== want) ctrl_ok = 1'b0;
            end
            if (done === 1'b1) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
            fails++;
            $display("FAIL reset_outputs: busy=%b done=%b result=%h expected 0/0/0", busy, done, result);
        end
        tests++;
        if (alu_control !== 3'b010 || alu_left !== '0 || alu_right !== '0) begin
            fails++;
            $display("FAIL reset_alu: ctrl=%b left=%h right=%h expected 010/0/0", alu_control, alu_left, alu_right);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mulu();
        int cyc, bn; bit ok;
        run_op(2'b00, 32'd7, 32'd6, "mulu_7x6", cyc, bn, ok);
        tests++;
        if (cyc !== 33) begin
            fails++;
            $display("FAIL mulu_done_latency: done at cycle %0d expected 33", cyc);
        end
        tests++;
        if (bn !== 32) begin
            fails++;
            $display("FAIL mulu_busy_cycles: busy cycles=%0d expected 32", bn);
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL mulu_alu_control: non-ADD seen during RUN, expected 010");
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL mulu_busy_in_done: busy=%b expected 0", busy);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || result !== 32'd42) begin
            fails++;
            $display("FAIL mulu_hold: done=%b result=%h expected 0/0000002a", done, result);
        end
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulu_ones", cyc, bn, ok);
        @(negedge clk);
        run_op(2'b00, 32'h0001_0000, 32'h0001_0000, "mulu_overflow", cyc, bn, ok);
        @(negedge clk);
        run_op(2'b11, 32'd7, 32'd6, "op11_as_mulu", cyc, bn, ok);
        tests++;
        if (cyc !== 33 || !ok) begin
            fails++;
            $display("FAIL op11_timing: done at %0d ctrl_ok=%0d expected 33/1", cyc, ok);
        end
        @(negedge clk);
    endtask

    task automatic test_divu();
        int cyc, bn; bit ok;
        run_op(2'b01, 32'd100, 32'd7, "divu_100_7", cyc, bn, ok);
        tests++;
        if (cyc !== 33 || bn !== 32) begin
            fails++;
            $display("FAIL divu_latency: done at %0d busy=%0d expected 33/32", cyc, bn);
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL divu_alu_control: non-SUB seen during RUN, expected 110");
        end
        @(negedge clk);
        run_op(2'b10, 32'd100, 32'd7, "remu_100_7", cyc, bn, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL remu_alu_control: non-SUB seen during RUN, expected 110");
        end
        @(negedge clk);
        run_op(2'b01, 32'h8000_0000, 32'd1, "divu_msb_by_1", cyc, bn, ok);
        @(negedge clk);
    endtask

    task automatic test_div_zero();
        int cyc, bn; bit ok;
        run_op(2'b01, 32'h1234, 32'd0, "divu_by_zero", cyc, bn, ok);
        @(negedge clk);
        run_op(2'b10, 32'h1234, 32'd0, "remu_by_zero", cyc, bn, ok);
        @(negedge clk);
        run_op(2'b01, 32'd5, 32'hFFFF_FFFF, "divu_by_max", cyc, bn, ok);
        @(negedge clk);
        run_op(2'b10, 32'd5, 32'hFFFF_FFFF, "remu_by_max", cyc, bn, ok);
        tests++;
        if (cyc !== 33) begin
            fails++;
            $display("FAIL remu_by_max_latency: done at %0d expected 33", cyc);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int cyc, bn; bit ok;
        logic [1:0]   o;
        logic [W-1:0] a, b;
        for (int i = 0; i < 6; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = (i % 2 == 0) ? W'($urandom_range(1, 1000)) : $urandom;
            run_op(o, a, b, "random_op", cyc, bn, ok);
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_start();
        exp_t ex;
        int   cyc;
        ex.val = model(2'b01, 32'd100, 32'd7);
        ex.name = "ignore_start_divu";
        exp_q.push_back(ex);
        op = 2'b01; operand_a = 32'd100; operand_b = 32'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        op = 2'b00; operand_a = 32'd3; operand_b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = -1;
        for (int k = 11; k <= 45; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                cyc = k;
                break;
            end
        end
        tests++;
        if (cyc !== 33) begin
            fails++;
            $display("FAIL ignore_start_latency: done at %0d expected 33", cyc);
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL ignore_start_not_queued: busy=%b expected 0", busy);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (result !== 32'd14) begin
            fails++;
            $display("FAIL ignore_start_hold: result=%h expected 0000000e", result);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bn; bit ok;
        run_op(2'b00, 32'd9, 32'd9, "b2b_first", cyc, bn, ok);
        // Still on the done negedge: this start lands in DONE.
        run_op(2'b10, 32'd100, 32'd7, "b2b_second", cyc, bn, ok);
        tests++;
        if (cyc !== 33 || bn !== 32) begin
            fails++;
            $display("FAIL b2b_latency: done at %0d busy=%0d expected 33/32", cyc, bn);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int cyc, bn; bit ok;
        op = 2'b01; operand_a = 32'h1234; operand_b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
            fails++;
            $display("FAIL reset_mid_outputs: busy=%b done=%b result=%h expected 0/0/0", busy, done, result);
        end
        tests++;
        if (alu_control !== 3'b010 || alu_left !== '0 || alu_right !== '0) begin
            fails++;
            $display("FAIL reset_mid_alu: ctrl=%b left=%h right=%h expected 010/0/0", alu_control, alu_left, alu_right);
        end
        reset = 1'b0;
        repeat (40) @(negedge clk);
        tests++;
        if (result !== '0) begin
            fails++;
            $display("FAIL reset_mid_no_completion: result=%h expected 0", result);
        end
        run_op(2'b00, 32'd3, 32'd5, "mulu_after_reset", cyc, bn, ok);
        tests++;
        if (cyc !== 33) begin
            fails++;
            $display("FAIL mulu_after_reset_latency: done at %0d expected 33", cyc);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_mulu();
        test_divu();
        test_div_zero();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        repeat (5) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d results pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
